nor_bank_bus: RTL and testbench

- Wishbone-slave to parallel-NOR bus driver, the multi-device successor of the single-chip NOR bus stage behind wb_nor_controller.
- Drives 2**CSBITS NOR devices that share address and data lines, each with its own CE# and RY/BY#.
- Setup, access and hold phases have parametrised timing; each access waits on the device's ready line, with a timeout.
- VT-mode WE suppression is handled inside the block instead of at top level.

---
 rtl/nor_bank_bus.sv | 151 +++++++++++++++
 tb/tb_nor_bank_bus.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_bank_bus.sv
// Wishbone slave driving a bank of parallel NOR devices that share address/data lines.
// Each access waits on the selected device's RY/BY#, then runs setup/strobe/hold timing.
module nor_bank_bus #(
   parameter int ADDRBITS = 26,
   parameter int DATABITS = 16,
   parameter int CSBITS   = 2,
   parameter int TSETUP   = 2,
   parameter int TACCESS  = 6,
   parameter int THOLD    = 2,
   parameter int TIMEOUT  = 4096
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [ADDRBITS+CSBITS-1:0] wb_adr_i,
   input  logic [DATABITS-1:0]        wb_dat_i,
   input  logic                       wb_we_i,
   input  logic                       wb_stb_i,
   input  logic                       wb_cyc_i,
   output logic                       wb_stall_o,
   output logic                       wb_ack_o,
   output logic                       wb_err_o,
   output logic [DATABITS-1:0]        wb_dat_o,
   input  logic                       vt_mode_i,
   input  logic [2**CSBITS-1:0]       nor_ry_i,
   input  logic [DATABITS-1:0]        nor_data_i,
   output logic [DATABITS-1:0]        nor_data_o,
   output logic [ADDRBITS-1:0]        nor_addr_o,
   output logic [2**CSBITS-1:0]       nor_ce_o,
   output logic                       nor_we_o,
   output logic                       nor_oe_o,
   output logic                       nor_data_oe,
   output logic                       busy_o
);

   localparam int NCHIPS = 2**CSBITS;
   localparam int CW     = $clog2(TIMEOUT + TSETUP + TACCESS + THOLD);

   typedef enum logic [2:0] {S_IDLE, S_WAITRY, S_SETUP, S_STROBE, S_HOLD} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [CSBITS-1:0]   r_chip;
   logic                r_we;
   logic                r_vt;
   logic [NCHIPS-1:0]   r_ry_meta;
   logic [NCHIPS-1:0]   r_ry_sync;

   logic [CSBITS-1:0]   w_adr_chip;
   logic                w_ry_s;
   logic                w_cnt_zero;

   assign w_adr_chip = wb_adr_i[ADDRBITS +: CSBITS];
   assign w_ry_s     = r_ry_sync[r_chip];
   assign w_cnt_zero = (r_cnt == '0);
   assign busy_o     = (r_state != S_IDLE);
   assign wb_stall_o = (r_state != S_IDLE);

   // RY/BY# is asynchronous to clk_i; preset low so a device is not trusted ready out of reset
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_ry_meta <= '0;
         r_ry_sync <= '0;
      end else begin
         r_ry_meta <= nor_ry_i;
         r_ry_sync <= r_ry_meta;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_chip      <= '0;
         r_we        <= 1'b0;
         r_vt        <= 1'b0;
         nor_ce_o    <= '1;
         nor_we_o    <= 1'b1;
         nor_oe_o    <= 1'b1;
         nor_data_oe <= 1'b0;
         nor_addr_o  <= '0;
         nor_data_o  <= '0;
         wb_dat_o    <= '0;
         wb_ack_o    <= 1'b0;
         wb_err_o    <= 1'b0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  r_chip      <= w_adr_chip;
                  r_we        <= wb_we_i;
                  r_vt        <= vt_mode_i;
                  nor_addr_o  <= wb_adr_i[ADDRBITS-1:0];
                  nor_ce_o    <= ~(NCHIPS'(1) << w_adr_chip);
                  nor_data_oe <= wb_we_i;
                  if (wb_we_i) nor_data_o <= wb_dat_i;
                  r_cnt       <= CW'(TIMEOUT - 1);
                  r_state     <= S_WAITRY;
               end
            end
            S_WAITRY: begin
               if (w_ry_s) begin
                  r_cnt   <= CW'(TSETUP - 1);
                  r_state <= S_SETUP;
               end else if (w_cnt_zero) begin
                  nor_ce_o    <= '1;
                  nor_data_oe <= 1'b0;
                  wb_err_o    <= wb_cyc_i;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_SETUP: begin
               if (w_cnt_zero) begin
                  r_cnt   <= CW'(TACCESS - 1);
                  r_state <= S_STROBE;
                  if (r_we) nor_we_o <= r_vt;
                  else      nor_oe_o <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_STROBE: begin
               if (w_cnt_zero) begin
                  r_cnt    <= CW'(THOLD - 1);
                  r_state  <= S_HOLD;
                  nor_oe_o <= 1'b1;
                  nor_we_o <= 1'b1;
                  if (!r_we) wb_dat_o <= nor_data_i;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (w_cnt_zero) begin
                  nor_ce_o    <= '1;
                  nor_data_oe <= 1'b0;
                  wb_ack_o    <= wb_cyc_i;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nor_bank_bus.sv
// Scoreboard bench for nor_bank_bus: stimulus queues expected completions, a monitor retires them.
module tb_nor_bank_bus;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [27:0] adr;
   logic [15:0] wdat;
   logic        we, stb, stb2, cyc, vt;
   logic [3:0]  ry, ry2;
   logic [15:0] mem;

   logic        stall1, ack1, err1, doe1, nwe1, noe1, busy1;
   logic [15:0] rdat1, dout1;
   logic [25:0] addr1;
   logic [3:0]  ce1;
   logic        stall2, ack2, err2, doe2, nwe2, noe2, busy2;
   logic [15:0] rdat2, dout2;
   logic [25:0] addr2;
   logic [3:0]  ce2;

   int checks = 0;
   int errors = 0;
   int cnum   = 0;

   typedef struct {
      bit          is_err;
      bit          chk_dat;
      logic [15:0] dat;
      int          at;
   } exp_t;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cnum <= cnum + 1;

   nor_bank_bus dut (
      .clk_i(clk), .reset_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
      .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_stall_o(stall1), .wb_ack_o(ack1), .wb_err_o(err1),
      .wb_dat_o(rdat1), .vt_mode_i(vt), .nor_ry_i(ry), .nor_data_i(mem), .nor_data_o(dout1),
      .nor_addr_o(addr1), .nor_ce_o(ce1), .nor_we_o(nwe1), .nor_oe_o(noe1),
      .nor_data_oe(doe1), .busy_o(busy1)
   );

   nor_bank_bus #(.TIMEOUT(16)) dut_to (
      .clk_i(clk), .reset_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_we_i(we),
      .wb_stb_i(stb2), .wb_cyc_i(cyc), .wb_stall_o(stall2), .wb_ack_o(ack2), .wb_err_o(err2),
      .wb_dat_o(rdat2), .vt_mode_i(vt), .nor_ry_i(ry2), .nor_data_i(mem), .nor_data_o(dout2),
      .nor_addr_o(addr2), .nor_ce_o(ce2), .nor_we_o(nwe2), .nor_oe_o(noe2),
      .nor_data_oe(doe2), .busy_o(busy2)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic retire(input int id, input logic ack, input logic err, input logic [15:0] dat);
      exp_t e;
      if (ack && err) check($sformatf("ack_err_together%0d", id), 1, 0);
      if (ack || err) begin
         checks++;
         if ((id == 0) ? (q1.size() == 0) : (q2.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_resp%0d: got ack=%0d err=%0d at cycle %0d expected none",
                     id, ack, err, cnum);
         end else begin
            e = (id == 0) ? q1.pop_front() : q2.pop_front();
            if (err !== e.is_err || cnum != e.at || (e.chk_dat && dat !== e.dat)) begin
               errors++;
               $display("FAIL resp%0d: got err=%0d cycle=%0d dat=%0h expected err=%0d cycle=%0d dat=%0h",
                        id, err, cnum, dat, e.is_err, e.at, e.dat);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      retire(0, ack1, err1, rdat1);
      retire(1, ack2, err2, rdat2);
   end

   // waveform statistics gathered by watch()
   logic [3:0]  exp_ce;
   logic [15:0] exp_dout;
   int n_ce, n_oe, n_we, n_both, n_doe, n_dbad, n_busy, we_first, drop_at;

   task automatic start(input logic [1:0] chip, input logic [25:0] a, input logic w,
                        input logic [15:0] d, input logic v, input bit to_dut2, output int k);
      @(negedge clk);
      adr = {chip, a}; wdat = d; we = w; vt = v; cyc = 1'b1;
      if (to_dut2) stb2 = 1'b1; else stb = 1'b1;
      k = cnum;
   endtask

   task automatic watch(input int n);
      n_ce = 0; n_oe = 0; n_we = 0; n_both = 0; n_doe = 0; n_dbad = 0; n_busy = 0;
      we_first = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         stb = 1'b0; stb2 = 1'b0;
         if (i == 2) vt = 1'b0;
         if (i == drop_at) cyc = 1'b0;
         if (ce1 == exp_ce) n_ce++;
         if (!noe1) n_oe++;
         if (!nwe1) begin n_we++; if (we_first < 0) we_first = i - 1; end
         if (!noe1 && !nwe1) n_both++;
         if (doe1) begin n_doe++; if (dout1 !== exp_dout) n_dbad++; end
         if (busy1) n_busy++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0; adr = '0; wdat = '0; we = 0; stb = 0; stb2 = 0; cyc = 0; vt = 0;
      ry = 4'hF; ry2 = 4'h0; mem = 16'h0; drop_at = 0;
      repeat (3) @(negedge clk);
      check("rst_ce", ce1, 4'hF);
      check("rst_we_oe", {nwe1, noe1}, 2'b11);
      check("rst_doe_busy_ack", {doe1, busy1, stall1, ack1, err1}, 5'b0);
      check("rst_addr_data", {addr1, dout1, rdat1}, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // read chip 2
      mem = 16'hBEEF; exp_ce = 4'b1011;
      start(2'd2, 26'h0123456, 0, 16'h0, 0, 0, k);
      q1.push_back('{0, 1, 16'hBEEF, k + 12});
      watch(12);
      check("rd_ce_cycles", n_ce, 11);
      check("rd_oe_cycles", n_oe, 6);
      check("rd_we_never", n_we, 0);
      check("rd_doe_never", n_doe, 0);
      check("rd_addr", addr1, 26'h0123456);
      check("rd_ce_released", ce1, 4'hF);

      // write chip 0
      exp_ce = 4'b1110; exp_dout = 16'hA5A5;
      start(2'd0, 26'h0000042, 1, 16'hA5A5, 0, 0, k);
      q1.push_back('{0, 0, 16'h0, k + 12});
      watch(12);
      check("wr_we_cycles", n_we, 6);
      check("wr_we_start", we_first, 3);
      check("wr_doe_cycles", n_doe, 11);
      check("wr_dout_bad", n_dbad, 0);
      check("wr_oe_never", n_oe, 0);
      check("wr_oe_we_overlap", n_both, 0);

      // write in VT mode, vt_mode_i dropped mid-access
      start(2'd0, 26'h0000043, 1, 16'hA5A5, 1, 0, k);
      q1.push_back('{0, 0, 16'h0, k + 12});
      watch(12);
      check("vt_we_never", n_we, 0);
      check("vt_doe_cycles", n_doe, 11);

      // chip 1 not ready for 100 cycles
      ry[1] = 1'b0; mem = 16'h0F0F; exp_ce = 4'b1101;
      repeat (3) @(negedge clk);
      start(2'd1, 26'h0000100, 0, 16'h0, 0, 0, k);
      q1.push_back('{0, 1, 16'h0F0F, k + 113});
      repeat (100) begin @(negedge clk); stb = 1'b0; end
      check("ry_wait_busy", busy1, 1);
      check("ry_wait_oe", noe1, 1);
      ry[1] = 1'b1;
      watch(13);
      check("ry_oe_cycles", n_oe, 6);

      // ready timeout on the short-timeout instance
      start(2'd1, 26'h0000200, 0, 16'h0, 0, 1, k);
      q2.push_back('{1, 0, 16'h0, k + 17});
      repeat (5) begin @(negedge clk); stb2 = 1'b0; end
      check("to_ce_waiting", ce2, 4'b1101);
      repeat (12) @(negedge clk);
      check("to_ce_released", ce2, 4'hF);
      check("to_idle", busy2, 0);
      check("to_oe_we", {noe2, nwe2}, 2'b11);

      // asynchronous reset during the strobe of a write
      start(2'd3, 26'h0000300, 1, 16'h3C3C, 0, 0, k);
      repeat (5) begin @(negedge clk); stb = 1'b0; end
      check("rs_we_low_before", nwe1, 0);
      #2 rst_n = 1'b0;
      #1;
      check("rs_we", nwe1, 1);
      check("rs_ce", ce1, 4'hF);
      check("rs_doe", doe1, 0);
      check("rs_idle", busy1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      mem = 16'h7777; exp_ce = 4'b0111;
      start(2'd3, 26'h0000301, 0, 16'h0, 0, 0, k);
      q1.push_back('{0, 1, 16'h7777, k + 12});
      watch(12);
      check("rs_rd_oe_cycles", n_oe, 6);
      check("rs_rd_ce_cycles", n_ce, 11);

      // wb_cyc_i dropped during setup: full timing, no ack
      exp_ce = 4'b1011; drop_at = 2; mem = 16'hDEAD;
      start(2'd2, 26'h0000400, 0, 16'h0, 0, 0, k);
      watch(12);
      drop_at = 0;
      check("drop_busy_cycles", n_busy, 11);
      check("drop_oe_cycles", n_oe, 6);
      check("drop_dat", rdat1, 16'hDEAD);
      repeat (2) @(negedge clk);

      // back-to-back requests with strobe held high
      mem = 16'h1234;
      start(2'd0, 26'h0000010, 0, 16'h0, 0, 0, k);
      q1.push_back('{0, 1, 16'h1234, k + 12});
      q1.push_back('{0, 1, 16'h4321, k + 24});
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 1) adr = {2'd0, 26'h0000020};
         if (i == 12) begin check("b2b_idle_gap", busy1, 0); mem = 16'h4321; end
         if (i == 13) begin
            stb = 1'b0;
            check("b2b_second_accepted", busy1, 1);
            check("b2b_second_addr", addr1, 26'h0000020);
         end
      end

      repeat (3) @(negedge clk);
      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
